// File: rtl/Asynchronous_FIFO_pkg.sv
// Asynchronous_FIFO_pkg: shared FIFO constants plus write-port arbiter defaults, state type and one-hot helper
package Asynchronous_FIFO_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;
  localparam int MAX_REQ        = 8;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request after i_last wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_owner,
  output logic         o_valid
);
  int w_j;
  always_comb begin
    o_owner = '0;
    w_j = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = int'(i_last) + k;
      w_j = w_j >= N ? w_j - N : w_j;
      o_owner = i_req[w_j[W-1:0]] ? w_j[W-1:0] : o_owner;
    end
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the FIFO write port, bursts of up to MAX_BURST words per grant.
// Defining FIFO_ARB_STATS_EN adds per-producer word counters and a full-stall counter.
module fifo_wr_arbiter
  import Asynchronous_FIFO_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk_wr,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         word_cnt,
  output logic [15:0]                   stall_cnt
`endif
);
  localparam int W  = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [W-1:0]       r_last;
  logic [CW-1:0]      r_cnt;
  logic [W-1:0]       w_owner;
  logic               w_valid;
  logic               w_own_req;
  logic               w_wr;
  logic [MAX_REQ-1:0] w_oh;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_owner (w_owner),
    .o_valid (w_valid)
  );
  assign w_oh      = onehot(3'(w_owner));
  // r_last doubles as the current owner while in BURST
  assign w_own_req = req[r_last];
  assign w_wr      = (r_state == ARB_BURST) && w_own_req && !full;
  assign ack       = w_wr ? r_gnt : '0;
  assign wr_en     = w_wr;
  assign data_in   = w_wr ? req_data[r_last*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy      = r_state == ARB_BURST;
  assign gnt       = r_gnt;
  always_ff @(posedge clk_wr or posedge rst)
    if (rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_last  <= W'(NUM_REQ - 1);
    end else if (r_state == ARB_IDLE) begin
      if (w_valid) begin
        r_state <= ARB_BURST;
        r_gnt   <= w_oh[NUM_REQ-1:0];
        r_last  <= w_owner;
        r_cnt   <= '0;
      end
    end else if (!w_own_req || (w_wr && r_cnt == CW'(MAX_BURST - 1))) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else if (w_wr)
      r_cnt <= r_cnt + 1'b1;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_word_cnt;
  logic [15:0]              r_stall_cnt;
  always_ff @(posedge clk_wr or posedge rst)
    if (rst) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (ack[i]) r_word_cnt[i] <= r_word_cnt[i] + 16'd1;
      if (busy && full && w_own_req && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  assign word_cnt  = r_word_cnt;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic checked every cycle against a transaction-level model
module tb_fifo_wr_arbiter;
  localparam int N = 4, MB = 4, DW = 8;
  logic clk_wr = 0, rst = 1, full = 0;
  logic [N-1:0] req = '0, ack, gnt;
  logic [N*DW-1:0] req_data = '0;
  logic wr_en, busy;
  logic [DW-1:0] data_in;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] word_cnt;
  logic [15:0] stall_cnt;
`endif
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_wr(clk_wr), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .gnt(gnt),
    .full(full), .wr_en(wr_en), .data_in(data_in), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk_wr = ~clk_wr;
  int tests = 0, fails = 0, cyc = 0;
  int rem[N];
  logic [DW-1:0] nxt[N];
  bit [N-1:0] en;
  bit m_busy;
  int m_owner, m_last, m_cnt, m_stall;
  int m_words[N];
  int log_cyc[$], log_own[$];
  logic [DW-1:0] log_dat[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = rem[i] > 0 && en[i];
      req_data[i*DW +: DW] = nxt[i];
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_words[i] = 0;
    log_cyc.delete(); log_own.delete(); log_dat.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    @(posedge clk_wr); #1;
    rst = 1;
    drive();
    #1;
    chk("rst_gnt", gnt, 0); chk("rst_wr_en", wr_en, 0); chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0); chk("rst_data", data_in, 0);
    @(posedge clk_wr); #1;
    rst = 0;
    m_reset();
  endtask

  // one cycle: drive, compare against the model mid-cycle, advance the model, cross the edge
  task automatic tick();
    logic [N-1:0] ea;
    drive();
    #4;
    ea = '0;
    if (m_busy && req[m_owner] && !full) ea[m_owner] = 1'b1;
    chk("ack", ack, ea);
    chk("gnt", gnt, m_busy ? (64'd1 << m_owner) : 64'd0);
    chk("wr_en", wr_en, |ea);
    chk("data_in", data_in, ea != 0 ? nxt[m_owner] : '0);
    chk("busy", busy, m_busy);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("word_cnt", word_cnt[i*16 +: 16], 16'(m_words[i]));
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (wr_en) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(data_in);
      for (int i = 0; i < N; i++) if (gnt[i]) log_own.push_back(i);
    end
    if (m_busy && req[m_owner] && full && m_stall < 65535) m_stall++;
    if (!m_busy) begin
      if (req != 0) begin
        for (int k = 1; k <= N; k++)
          if (req[(m_last + k) % N]) begin m_owner = (m_last + k) % N; break; end
        m_last = m_owner; m_busy = 1; m_cnt = 0;
      end
    end else if (!req[m_owner]) m_busy = 0;
    else if (ea != 0) begin
      m_cnt++;
      if (m_cnt == MB) m_busy = 0;
    end
    for (int i = 0; i < N; i++)
      if (ea[i]) begin rem[i]--; nxt[i]++; m_words[i]++; end
    @(posedge clk_wr); #1;
    cyc++;
  endtask

  task automatic setup(input int r0, input int r1, input int r2, input int r3);
    rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    for (int i = 0; i < N; i++) nxt[i] = 8'(i * 16);
    en = '1;
    full = 0;
  endtask

  initial begin
    bit hit;
    int exp1_c[6] = '{1, 2, 3, 4, 6, 7};
    int exp3_c[4] = '{1, 2, 6, 7};
    int exp4_c[5] = '{1, 4, 5, 6, 7};
    int exp4_o[5] = '{0, 3, 3, 3, 3};
    // single requester, 6 words: burst of 4, bubble, burst of 2
    setup(0, 0, 6, 0); nxt[2] = 8'hA0;
    do_reset();
    for (int c = 0; c < 10; c++) tick();
    chk("s1_nwr", log_cyc.size(), 6);
    for (int k = 0; k < 6 && k < log_cyc.size(); k++) begin
      chk("s1_cyc", log_cyc[k], exp1_c[k]);
      chk("s1_dat", log_dat[k], 8'hA0 + 8'(k));
      chk("s1_own", log_own[k], 2);
    end
    // all requesters: order 0,1,2,3,0 with 4-word bursts and one bubble
    setup(100, 100, 100, 100);
    do_reset();
    for (int c = 0; c < 25; c++) tick();
    chk("s2_nwr", log_cyc.size(), 20);
    for (int k = 0; k < 20 && k < log_cyc.size(); k++) begin
      chk("s2_own", log_own[k], (k / 4) % 4);
      chk("s2_cyc", log_cyc[k], 1 + (k / 4) * 5 + k % 4);
    end
    // owner 1 stalled by full for 3 cycles after 2 writes
    setup(0, 4, 0, 0);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      full = cyc >= 3 && cyc <= 5;
      tick();
    end
    full = 0;
    chk("s3_nwr", log_cyc.size(), 4);
    for (int k = 0; k < 4 && k < log_cyc.size(); k++) chk("s3_cyc", log_cyc[k], exp3_c[k]);
    // owner 0 drops after one word, requester 3 takes over
    setup(1, 0, 0, 5);
    do_reset();
    for (int c = 0; c < 9; c++) tick();
    chk("s4_nwr", log_cyc.size(), 5);
    for (int k = 0; k < 5 && k < log_cyc.size(); k++) begin
      chk("s4_cyc", log_cyc[k], exp4_c[k]);
      chk("s4_own", log_own[k], exp4_o[k]);
    end
    // asynchronous reset during owner 2's third write
    setup(100, 100, 100, 100);
    do_reset();
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (m_busy && m_owner == 2 && m_cnt == 2) hit = 1;
      else tick();
    end
    chk("s5_reached", hit, 1);
    drive(); #2;
    chk("s5_pre_gnt", gnt, 4'b0100); chk("s5_pre_wr", wr_en, 1);
    rst = 1; #1;
    chk("s5_gnt", gnt, 0); chk("s5_wr_en", wr_en, 0); chk("s5_ack", ack, 0); chk("s5_busy", busy, 0);
    @(posedge clk_wr); #1;
    rst = 0;
    m_reset();
    tick();
    drive(); #1;
    chk("s5_regrant", gnt, 4'b0001);
    @(posedge clk_wr); #1;
    m_reset();
    // randomized traffic: sporadic producers, random full
    setup(0, 0, 0, 0);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 9);
        en[i] = $urandom_range(0, 9) != 0;
      end
      full = $urandom_range(0, 3) == 0;
      tick();
    end
    full = 0;
`ifdef FIFO_ARB_STATS_EN
    // 40 cycles of full contention, then 5 stalled burst cycles
    setup(100, 100, 100, 100);
    do_reset();
    for (int c = 0; c < 46; c++) begin
      full = cyc >= 40;
      tick();
    end
    for (int i = 0; i < N; i++) chk("st_words", word_cnt[i*16 +: 16], 16'd8);
    chk("st_stall", stall_cnt, 16'd5);
    full = 0;
    do_reset();
    chk("st_rst_words", word_cnt, 0);
    chk("st_rst_stall", stall_cnt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
